// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment score reader.
// Patterns are active-low with bit order g f e d c b a (bit6..bit0).
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] MAX_TENS  = 4'd3;
    localparam logic [6:0] MAX_VALUE = 7'd31;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_TENS  = 2'd1,
        S_EVAL  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_score_reader_decode.sv
// Combinational decode of one active-low segment pattern to a BCD digit.
// A blank pattern is only legal where allow_blank is set and reads as 0.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] code,
    input  logic       allow_blank,
    output logic [3:0] digit,
    output logic       ok
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        case (code)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: ok    = allow_blank;
            default:   ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_score_reader.sv
// Recovers a 0..31 score from a multiplexed two-digit 7-segment stream and
// only publishes it after STABLE_FRAMES consecutive identical good frames.
module seg7_score_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_valid,
    input  logic       seg_digit,
    input  logic [6:0] seg_code,
    output logic [4:0] value,
    output logic       value_valid,
    output logic       locked,
    output logic       frame_err
);

    localparam int             CW      = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_FRAMES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    state_t        state;
    state_t        state_n;
    logic          cap_units;
    logic          cap_tens;
    logic          do_eval;

    logic [3:0]    dec_digit;
    logic          dec_ok;

    logic [3:0]    units_d;
    logic          units_ok;
    logic [3:0]    tens_d;
    logic          tens_ok;
    logic [CW-1:0] cnt;
    logic [4:0]    cand;

    logic [6:0]    sum;
    logic          frame_bad;
    logic [CW-1:0] cnt_n;
    logic [4:0]    cand_n;
    logic          confirm;

    // Tens strobes are the only place a blank pattern is acceptable.
    seg7_digit_decode u_decode (
        .code        (seg_code),
        .allow_blank (seg_digit),
        .digit       (dec_digit),
        .ok          (dec_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_UNITS;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_UNITS: if (seg_valid && !seg_digit) state_n = S_TENS;
            S_TENS:  if (seg_valid && seg_digit)  state_n = S_EVAL;
            S_EVAL:  state_n = (seg_valid && !seg_digit) ? S_TENS : S_UNITS;
            default: state_n = S_UNITS;
        endcase
    end

    // A units strobe is taken in every state: it starts, restarts or
    // pipelines the next frame behind the evaluation cycle.
    always_comb begin
        cap_units = 1'b0;
        cap_tens  = 1'b0;
        do_eval   = 1'b0;
        case (state)
            S_UNITS: cap_units = seg_valid && !seg_digit;
            S_TENS: begin
                cap_units = seg_valid && !seg_digit;
                cap_tens  = seg_valid && seg_digit;
            end
            S_EVAL: begin
                cap_units = seg_valid && !seg_digit;
                do_eval   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sum       = 7'(tens_d) * 7'd10 + 7'(units_d);
        frame_bad = !units_ok || !tens_ok || (tens_d > MAX_TENS) || (sum > MAX_VALUE);
        cand_n    = cand;
        cnt_n     = cnt;
        if (sum == {2'b00, cand}) begin
            cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end else begin
            cand_n = sum[4:0];
            cnt_n  = CNT_ONE;
        end
        confirm = do_eval && !frame_bad && (cnt_n == CNT_MAX) &&
                  (!locked || (cand_n != value));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            units_d     <= 4'd0;
            units_ok    <= 1'b0;
            tens_d      <= 4'd0;
            tens_ok     <= 1'b0;
            cnt         <= '0;
            cand        <= 5'd0;
            value       <= 5'd0;
            value_valid <= 1'b0;
            locked      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (cap_units) begin
                units_d  <= dec_digit;
                units_ok <= dec_ok;
            end
            if (cap_tens) begin
                tens_d  <= dec_digit;
                tens_ok <= dec_ok;
            end
            if (do_eval) begin
                if (frame_bad) begin
                    frame_err <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt  <= cnt_n;
                    cand <= cand_n;
                end
            end
            if (confirm) begin
                value       <= cand_n;
                value_valid <= 1'b1;
                locked      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_score_reader.sv
// Bench for seg7_score_reader: directed frame scenarios plus random frames
// checked against a history-based model of the confirmation rule.
module tb_seg7_score_reader;

    localparam int SF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seg_valid = 1'b0;
    logic       seg_digit = 1'b0;
    logic [6:0] seg_code = 7'h7f;
    logic [4:0] value;
    logic       value_valid;
    logic       locked;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK = 7'b1111111;

    // Model: last SF good frame sums; cleared by a bad frame.
    int         hist[$];
    logic [4:0] m_value;
    bit         m_locked;
    bit         exp_vv;
    bit         exp_err;
    int         m_err_cnt;
    int         seen_err;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    always #5 clk = ~clk;

    seg7_score_reader #(.STABLE_FRAMES(SF)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_valid   (seg_valid),
        .seg_digit   (seg_digit),
        .seg_code    (seg_code),
        .value       (value),
        .value_valid (value_valid),
        .locked      (locked),
        .frame_err   (frame_err)
    );

    // Scoreboard: every value_valid pulse must match the next expected value.
    always @(negedge clk) begin
        if (!rst) begin
            if (value_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_value_valid: got value=%0d, no update expected", value);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (value !== mon_exp) begin
                        n_err++;
                        $display("FAIL scoreboard_value: got %0d expected %0d", value, mon_exp);
                    end
                end
            end
            if (frame_err) seen_err++;
        end
    end

    function automatic int dec(logic [6:0] c, bit is_tens);
        for (int i = 0; i < 10; i++) if (c == pat[i]) return i;
        if (is_tens && c == BLANK) return 0;
        return -1;
    endfunction

    function automatic logic [6:0] enc(int d);
        return pat[d];
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        m_value  = 5'd0;
        m_locked = 1'b0;
        exp_vv   = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic model_frame(input logic [6:0] u, input logic [6:0] t);
        int  du, dt, s;
        bit  all_same;
        du = dec(u, 1'b0);
        dt = dec(t, 1'b1);
        exp_vv  = 1'b0;
        exp_err = 1'b0;
        if (du < 0 || dt < 0 || dt * 10 + du > 31) begin
            exp_err = 1'b1;
            m_err_cnt++;
            hist.delete();
        end else begin
            s = dt * 10 + du;
            hist.push_back(s);
            if (hist.size() > SF) void'(hist.pop_front());
            all_same = (hist.size() == SF);
            foreach (hist[i]) if (hist[i] != s) all_same = 1'b0;
            if (all_same && (!m_locked || 5'(s) != m_value)) begin
                m_value  = 5'(s);
                m_locked = 1'b1;
                exp_vv   = 1'b1;
                exp_q.push_back(m_value);
            end
        end
    endtask

    task automatic strobe(input bit d, input logic [6:0] c);
        @(negedge clk);
        seg_valid = 1'b1;
        seg_digit = d;
        seg_code  = c;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_digit = 1'($urandom);
        seg_code  = 7'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        seg_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one frame and returns at the negedge where its result is visible.
    task automatic send_frame(input logic [6:0] u, input logic [6:0] t);
        strobe(1'b0, u);
        strobe(1'b1, t);
        model_frame(u, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_value(input int v, input int reps, input string name);
        for (int i = 0; i < reps; i++) begin
            send_frame(enc(v % 10), enc(v / 10));
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== {m_value, exp_vv, exp_err, m_locked}) begin
                n_err++;
                $display("FAIL %s[%0d]: value=%0d vv=%b err=%b locked=%b, expected value=%0d vv=%b err=%b locked=%b",
                         name, i, value, value_valid, frame_err, locked, m_value, exp_vv, exp_err, m_locked);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== 8'b0) begin
                n_err++;
                $display("FAIL reset: value=%0d vv=%b err=%b locked=%b, expected all zero",
                         value, value_valid, frame_err, locked);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_confirm();
        do_reset();
        send_value(23, 3, "confirm_23");
        @(negedge clk);
        n_vec++;
        if (value_valid !== 1'b0 || value !== 5'd23) begin
            n_err++;
            $display("FAIL confirm_pulse_width: vv=%b value=%0d, expected vv=0 value=23", value_valid, value);
        end
    endtask

    task automatic test_blank_tens();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_frame(enc(7), (i < 3) ? BLANK : enc(0));
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== {m_value, exp_vv, exp_err, m_locked}) begin
                n_err++;
                $display("FAIL blank_tens[%0d]: value=%0d vv=%b err=%b, expected value=%0d vv=%b err=%b",
                         i, value, value_valid, frame_err, m_value, exp_vv, exp_err);
            end
        end
        send_frame(BLANK, enc(1));
        n_vec++;
        if (frame_err !== 1'b1 || value !== 5'd7) begin
            n_err++;
            $display("FAIL blank_units: err=%b value=%0d, expected err=1 value=7", frame_err, value);
        end
    endtask

    task automatic test_bad_frame();
        do_reset();
        send_value(23, 3, "bad_lock23");
        send_frame(7'b0000001, enc(2));
        n_vec++;
        if (frame_err !== 1'b1 || value_valid !== 1'b0 || value !== 5'd23) begin
            n_err++;
            $display("FAIL bad_units: err=%b vv=%b value=%0d, expected err=1 vv=0 value=23",
                     frame_err, value_valid, value);
        end
        @(negedge clk);
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL bad_err_width: err=%b, expected 0", frame_err);
        end
        send_value(24, 3, "bad_then_24");
    endtask

    task automatic test_range();
        send_value(35, 1, "range_35");
        send_value(40, 1, "range_40");
        send_value(31, 3, "range_31");
    endtask

    task automatic test_glitch();
        int seq [8] = '{23, 23, 17, 23, 23, 24, 24, 24};
        do_reset();
        send_value(23, 3, "glitch_lock");
        foreach (seq[i]) send_value(seq[i], 1, "glitch_seq");
    endtask

    task automatic test_resync();
        do_reset();
        strobe(1'b0, enc(3));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        strobe(1'b1, enc(2));
        strobe(1'b1, enc(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== 8'b0) begin
                n_err++;
                $display("FAIL resync_no_eval[%0d]: value=%0d vv=%b err=%b locked=%b, expected all zero",
                         i, value, value_valid, frame_err, locked);
            end
        end
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, enc(9));
            strobe(1'b0, enc(3));
            strobe(1'b1, enc(2));
            model_frame(enc(3), enc(2));
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== {m_value, exp_vv, exp_err, m_locked}) begin
                n_err++;
                $display("FAIL units_overwrite[%0d]: value=%0d vv=%b err=%b, expected value=%0d vv=%b err=%b",
                         i, value, value_valid, frame_err, m_value, exp_vv, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        int vals [7] = '{12, 12, 12, 5, 5, 5, 5};
        strobe(1'b0, enc(vals[0] % 10));
        for (int i = 0; i < 7; i++) begin
            strobe(1'b1, enc(vals[i] / 10));
            model_frame(enc(vals[i] % 10), enc(vals[i] / 10));
            if (i < 6) strobe(1'b0, enc(vals[i + 1] % 10));
            else @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== {m_value, exp_vv, exp_err, m_locked}) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: value=%0d vv=%b err=%b, expected value=%0d vv=%b err=%b",
                         i, value, value_valid, frame_err, m_value, exp_vv, exp_err);
            end
        end
    endtask

    task automatic test_random();
        int a, b, v;
        logic [6:0] u, t;
        do_reset();
        a = $urandom_range(0, 31);
        b = $urandom_range(0, 31);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       v = $urandom_range(0, 45);
                1, 2, 3: v = b;
                default: v = a;
            endcase
            if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 31);
            u = enc(v % 10);
            t = (v < 10 && $urandom_range(0, 1) == 1) ? BLANK : enc(v / 10);
            if ($urandom_range(0, 11) == 0) u = 7'($urandom);
            if ($urandom_range(0, 15) == 0) t = 7'($urandom);
            send_frame(u, t);
            n_vec++;
            if ({value, value_valid, frame_err, locked} !== {m_value, exp_vv, exp_err, m_locked}) begin
                n_err++;
                $display("FAIL random[%0d] u=%b t=%b: value=%0d vv=%b err=%b locked=%b, expected value=%0d vv=%b err=%b locked=%b",
                         i, u, t, value, value_valid, frame_err, locked, m_value, exp_vv, exp_err, m_locked);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                n_vec++;
                if (value_valid !== 1'b0 || frame_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL random_idle[%0d]: vv=%b err=%b, expected 0 0", i, value_valid, frame_err);
                end
            end
        end
    endtask

    initial begin
        m_err_cnt = 0;
        seen_err  = 0;
        model_reset();
        test_reset();
        test_confirm();
        test_blank_tens();
        test_bad_frame();
        test_range();
        test_glitch();
        test_resync();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_value_valid: %0d expected updates never seen", exp_q.size());
        end
        n_vec++;
        if (seen_err != m_err_cnt) begin
            n_err++;
            $display("FAIL frame_err_count: got %0d pulses expected %0d", seen_err, m_err_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
